// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter: bus widths,
// transfer-sequencer state encoding and port-select constants.
package spi_bus_arbiter_pkg;

   localparam int BUS_ADDR_W = 7;
   localparam int BUS_DATA_W = 8;
   localparam int CNT_W      = 4;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Round-robin choice between two requesters; on a tie the port that did
   // not win last time goes next. Result is meaningless with no request.
   function automatic logic rr_pick(input logic req_a, input logic req_b,
                                    input logic owner);
      logic pick;
      if (req_a && req_b) pick = ~owner;
      else if (req_b)     pick = PORT_B;
      else                pick = PORT_A;
      return pick;
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; owner is the last granted port.
module rr_arbiter2
   import spi_bus_arbiter_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic owner,
   output logic grant_valid,
   output logic grant_port
);

   assign grant_valid = req_a | req_b;
   assign grant_port  = rr_pick(req_a, req_b, owner);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one address/data peripheral bus between the SPI controller (A) and
// the scan/refresh engine (B); each transfer runs setup -> strobe -> hold.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and latch the winning request
// SETUP  | address (and write data) on the bus, strobes high
// STROBE | read_n or write_n low for WAIT_CYC cycles
// HOLD   | strobes high, bus held, ack to the granted port
module spi_bus_arbiter
   import spi_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = BUS_ADDR_W,
   parameter int DATA_W   = BUS_DATA_W,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              ack_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic [ADDR_W-1:0] address_bus,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic [DATA_W-1:0] data_in,
   output logic              read_n,
   output logic              write_n,
   output logic              busy,
   output logic              owner
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              owner_nxt;
   logic              grant_valid, grant_port;
   logic              latch_en, sample_en;
   logic              we_q, port_q;
   logic              read_n_nxt, write_n_nxt, data_oe_nxt;
   logic              ack_a_nxt, ack_b_nxt;
   logic              g_we;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;

   rr_arbiter2 u_rr_arbiter2 (
      .req_a       (req_a),
      .req_b       (req_b),
      .owner       (owner),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   assign g_we    = (grant_port == PORT_B) ? we_b    : we_a;
   assign g_addr  = (grant_port == PORT_B) ? addr_b  : addr_a;
   assign g_wdata = (grant_port == PORT_B) ? wdata_b : wdata_a;

   assign busy = (state != IDLE);

   // Outputs are computed one cycle ahead and registered, so the bus pins
   // never see a combinational path from the requesters.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      owner_nxt   = owner;
      latch_en    = 1'b0;
      sample_en   = 1'b0;
      read_n_nxt  = 1'b1;
      write_n_nxt = 1'b1;
      data_oe_nxt = data_oe;
      ack_a_nxt   = 1'b0;
      ack_b_nxt   = 1'b0;

      case (state)
         IDLE: begin
            data_oe_nxt = 1'b0;
            if (grant_valid) begin
               latch_en    = 1'b1;
               owner_nxt   = grant_port;
               data_oe_nxt = g_we;
               state_nxt   = SETUP;
            end
         end
         SETUP: begin
            cnt_nxt     = CNT_LOAD;
            read_n_nxt  = we_q;
            write_n_nxt = ~we_q;
            state_nxt   = STROBE;
         end
         STROBE: begin
            if (cnt == '0) begin
               sample_en = ~we_q;
               ack_a_nxt = (port_q == PORT_A);
               ack_b_nxt = (port_q == PORT_B);
               state_nxt = HOLD;
            end else begin
               cnt_nxt     = cnt - 1'b1;
               read_n_nxt  = we_q;
               write_n_nxt = ~we_q;
            end
         end
         HOLD: begin
            data_oe_nxt = 1'b0;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         owner   <= PORT_B;
         we_q    <= 1'b0;
         port_q  <= PORT_A;
         read_n  <= 1'b1;
         write_n <= 1'b1;
         data_oe <= 1'b0;
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         owner   <= owner_nxt;
         read_n  <= read_n_nxt;
         write_n <= write_n_nxt;
         data_oe <= data_oe_nxt;
         ack_a   <= ack_a_nxt;
         ack_b   <= ack_b_nxt;
         if (latch_en) begin
            we_q   <= g_we;
            port_q <= grant_port;
         end
      end
   end

   // Bus address/data registers double as the latched request fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         address_bus <= '0;
         data_out    <= '0;
      end else if (latch_en) begin
         address_bus <= g_addr;
         if (g_we) data_out <= g_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else if (sample_en) begin
         if (port_q == PORT_B) rdata_b <= data_in;
         else                  rdata_a <= data_in;
      end
   end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single 7-bit address / 8-bit data peripheral bus (active-low read_n/write_n strobes) between two masters.
- Port A is the SPI-to-bus controller (SPI-decoded read/write requests). Port B is the local scan/refresh engine (LED/display refresh reads, status writes).
- Arbitrates with round-robin, then sequences each transfer as setup -> strobe (wait states) -> hold. Strobes are glitch-free and the data bus is driven only during writes.

Parameters:
- ADDR_W, 7, address width.
- DATA_W, 8, data width.
- WAIT_CYC, 2, strobe-low cycles per access (legal 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_a  in  1  port A request; held high until ack_a
- we_a  in  1  port A: 1 = write, 0 = read
- addr_a  in  ADDR_W  port A address
- wdata_a  in  DATA_W  port A write data
- ack_a  out  1  one-cycle completion pulse to port A
- rdata_a  out  DATA_W  port A read data, valid with ack_a
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same meaning for port B
- address_bus  out  ADDR_W  peripheral address
- data_out  out  DATA_W  write data toward the bus
- data_oe  out  1  tri-state enable for data_out
- data_in  in  DATA_W  bus read data
- read_n  out  1  active-low read strobe
- write_n  out  1  active-low write strobe
- busy  out  1  high in any state other than IDLE
- owner  out  1  0 = A, 1 = B; last granted port

Behaviour:
- Reset (asynchronous, active-high): read_n = 1, write_n = 1, data_oe = 0, address_bus = 0, data_out = 0, ack_a = ack_b = 0, rdata_a = rdata_b = 0, busy = 0, owner = 1 (so port A wins the first tie), FSM = IDLE.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the port other than owner.
  - On grant: latch we, addr and wdata into internal registers; update owner; go to SETUP.
  - No request: stay in IDLE.
- SETUP (1 cycle):
  - address_bus = latched address.
  - Write: data_out = latched data, data_oe = 1.
  - Both strobes stay high.
- STROBE (WAIT_CYC cycles, counted by a 4-bit counter):
  - Read asserts read_n = 0; write asserts write_n = 0. Never both.
  - Read: data_in is sampled into the granted port's rdata on the last STROBE cycle.
- HOLD (1 cycle):
  - Strobes high; address and data_oe held.
  - Granted port's ack pulses for exactly this cycle. Go to IDLE; data_oe = 0 on entry to IDLE.
- Latency: the grant cycle is the first IDLE cycle with req high. ack is asserted 2 + WAIT_CYC cycles after that grant cycle. Minimum period between back-to-back transfers is 3 + WAIT_CYC cycles.
- Requests and data are registered at grant. Requester changes to addr/wdata/we mid-transfer have no effect.
- req dropped mid-transfer: the transfer still completes and ack still pulses.
- req still high in the cycle after ack: treated as a new request and re-arbitrated in IDLE.
- rdata_x holds its value until the next read completion on that port. Writes do not modify rdata.
- Address and data outputs are registered; no combinational path from req to the bus pins.
- Reset asserted mid-transfer: strobes return high and data_oe drops immediately (asynchronous). No ack is issued; the interrupted transfer is lost.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3.
  - Bus widths ADDR_W / DATA_W, shared with spi_ctl.
  - Port-select constants PORT_A = 1'b0, PORT_B = 1'b1.
- One sub-module, rr_arbiter2: combinational grant from req_a, req_b and owner. Everything else stays in spi_bus_arbiter.

Test Plan:
1. Port A read, addr 0x05, data_in = 0xAA, WAIT_CYC = 2 -> read_n low exactly 2 cycles; ack_a 4 cycles after grant; rdata_a = 0xAA; write_n and data_oe stay inactive throughout.
2. Port B write, addr 0x7F, wdata 0x3C -> data_oe high from SETUP through HOLD; write_n low 2 cycles; address_bus = 0x7F and data_out = 0x3C stable for the whole strobe; ack_b one pulse.
3. req_a and req_b rise together after reset, both held -> A served first, then B, then A (round-robin); owner toggles 0, 1, 0; no overlapping strobes.
4. Port A drops req_a during STROBE and changes addr_a to 0x11 -> transfer finishes on the original address; ack_a still pulses.
5. Reset asserted in the first STROBE cycle of a write -> write_n = 1 and data_oe = 0 within the same cycle; no ack; busy = 0; the next request is served normally.
6. Port A requests held continuously, WAIT_CYC = 1 -> ack_a every 4 cycles; rdata_a tracks successive data_in values 0x01, 0x02, 0x03.
